// File: rtl/alu_pkg.sv
// Shared constants for the ALU command front end: default width, opcode map,
// controller state encoding and small opcode classification helpers.
package alu_pkg;

    localparam int DEF_DATA_W = 16;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_LT     = 4'd4;
    localparam logic [3:0] OP_ADDACC = 4'd5;
    localparam logic [3:0] OP_ANDACC = 4'd6;
    localparam logic [3:0] OP_ORACC  = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Opcodes 8-15 have no ALU meaning and are answered with an error response.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op != OP_NOP) && !op[3];
    endfunction

    function automatic logic uses_acc(input logic [3:0] op);
        return (op >= OP_ADDACC) && (op <= OP_ORACC);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Command-side front end for the stateless 16-bit ALU: accepts one command at a
// time, holds the ALU inputs for a fixed latency, returns the result and owns the accumulator.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ALU_LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              alu_enable,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_data_a,
    output logic [DATA_W-1:0] alu_data_b,
    input  logic [DATA_W-1:0] alu_results,
    input  logic              alu_cf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_cf,
    output logic              rsp_err,
    output logic [DATA_W-1:0] acc_out
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_cf_q;
    logic                rsp_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = is_alu_op(cmd_opcode) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        alu_enable = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE:  cmd_ready  = 1'b1;
            ST_ISSUE: alu_enable = 1'b1;
            ST_WAIT:  alu_enable = 1'b1;
            ST_RESP:  rsp_valid  = 1'b1;
            default:  ;
        endcase
    end

    // The ALU input registers are loaded only for real ALU ops, so they read zero
    // whenever alu_enable is low, including across NOP/illegal responses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            rsp_result_q <= '0;
            rsp_cf_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (is_alu_op(cmd_opcode)) begin
                            op_q <= cmd_opcode;
                            a_q  <= uses_acc(cmd_opcode) ? acc_q : cmd_a;
                            b_q  <= cmd_b;
                        end else begin
                            rsp_result_q <= '0;
                            rsp_cf_q     <= 1'b0;
                            rsp_err_q    <= is_illegal(cmd_opcode);
                        end
                    end
                end
                ST_ISSUE: cnt_q <= CNT_W'(ALU_LATENCY - 1);
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_result_q <= alu_results;
                        rsp_cf_q     <= alu_cf;
                        rsp_err_q    <= 1'b0;
                        if (uses_acc(op_q)) begin
                            acc_q <= alu_results;
                        end
                        op_q <= '0;
                        a_q  <= '0;
                        b_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_opcode = op_q;
    assign alu_data_a = a_q;
    assign alu_data_b = b_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cf     = rsp_cf_q;
    assign rsp_err    = rsp_err_q;
    assign acc_out    = acc_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU with fixed output delay, a
// transaction-level reference model checked every cycle, directed and random stimulus.
module tb_alu_issue_ctrl;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode = '0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          alu_enable;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_data_a;
    logic [DW-1:0] alu_data_b;
    logic [DW-1:0] alu_results;
    logic          alu_cf;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic          rsp_cf;
    logic          rsp_err;
    logic [DW-1:0] acc_out;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_issue_ctrl #(.DATA_W(DW), .ALU_LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode),
        .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
        .alu_results(alu_results), .alu_cf(alu_cf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cf(rsp_cf), .rsp_err(rsp_err),
        .acc_out(acc_out)
    );

    // ALU semantics as {carry, result}
    function automatic logic [DW:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] r;
        r = '0;
        case (op)
            4'd1, 4'd5: r = {1'b0, a} + {1'b0, b};
            4'd2, 4'd6: r = {1'b0, a & b};
            4'd3, 4'd7: r = {1'b0, a | b};
            4'd4:       r = (a < b) ? (DW+1)'(1) : '0;
            default:    r = '0;
        endcase
        return r;
    endfunction

    // Behavioural ALU: LAT-stage delay; garbage when not enabled exposes mistimed sampling
    logic [DW:0] pipe [LAT];
    always @(posedge CLK) begin
        pipe[0] <= alu_enable ? alu_fn(alu_opcode, alu_data_a, alu_data_b) : {1'b1, 16'hA5A5};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_results = pipe[LAT-1][DW-1:0];
    assign alu_cf      = pipe[LAT-1][DW];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction with timestamps
    int          cyc = 0;
    bit          started = 0;
    bit          m_busy = 0, m_alu = 0, m_pend = 0;
    int          m_en_s = 0, m_en_e = 0, m_rsp_s = 0;
    logic [3:0]  m_op = '0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0, m_acc = '0, m_acc_new = '0;
    logic        m_cf = 1'b0, m_err = 1'b0;

    initial forever begin
        @(posedge CLK);
        cyc++;
        if (RST) begin
            started = 1;
            m_busy = 0; m_alu = 0; m_pend = 0; m_acc = '0;
        end else if (m_busy) begin
            if ((cyc - 1) >= m_rsp_s && rsp_ready) begin
                m_busy = 0;
                if (m_pend) m_acc = m_acc_new;
                m_pend = 0;
            end
        end else if (cmd_valid) begin
            m_busy = 1;
            m_op   = cmd_opcode;
            m_b    = cmd_b;
            m_a    = (cmd_opcode >= 4'd5 && cmd_opcode <= 4'd7) ? m_acc : cmd_a;
            if (cmd_opcode == 4'd0 || cmd_opcode >= 4'd8) begin
                m_alu = 0; m_rsp_s = cyc;
                m_res = '0; m_cf = 1'b0; m_err = (cmd_opcode >= 4'd8);
            end else begin
                m_alu = 1; m_en_s = cyc; m_en_e = cyc + LAT; m_rsp_s = cyc + LAT + 1;
                {m_cf, m_res} = alu_fn(m_op, m_a, m_b);
                m_err = 1'b0;
                m_pend = (cmd_opcode >= 4'd5);
                m_acc_new = m_res;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (started) begin
            bit rv, en;
            rv = m_busy && (cyc >= m_rsp_s);
            en = m_busy && m_alu && (cyc >= m_en_s) && (cyc <= m_en_e);
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("rsp_valid", rsp_valid, rv);
            chk("alu_enable", alu_enable, en);
            chk("alu_opcode", alu_opcode, en ? m_op : 4'd0);
            chk("alu_data_a", alu_data_a, en ? m_a : '0);
            chk("alu_data_b", alu_data_b, en ? m_b : '0);
            if (rv) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_cf", rsp_cf, m_cf);
                chk("rsp_err", rsp_err, m_err);
            end
            chk("acc_out", acc_out, (m_pend && cyc >= m_rsp_s) ? m_acc_new : m_acc);
        end
    end

    task automatic run_cmd(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int bp, input bit keep,
                           output logic [DW-1:0] res, output logic cf, output logic err,
                           output int lat, output int en_cnt, output logic [DW-1:0] a_seen);
        int n;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge CLK); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=busy required=ready at %0t", $time);
        end
        @(negedge CLK);
        if (!keep) cmd_valid = 1'b0;
        lat = 1; en_cnt = 0; a_seen = '0; n = 0;
        while (!rsp_valid && n < 50) begin
            if (alu_enable) begin
                if (en_cnt == 0) a_seen = alu_data_a;
                en_cnt++;
            end
            @(negedge CLK); lat++; n++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout actual=no_valid required=valid at %0t", $time);
        end
        res = rsp_result; cf = rsp_cf; err = rsp_err;
        repeat (bp) begin
            @(negedge CLK);
            chk("bp_result", rsp_result, res);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] r, as;
        logic c, e;
        int lat, en, n;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_alu_enable", alu_enable, 1'b0);
        chk("rst_alu_opcode", alu_opcode, 4'd0);
        chk("rst_rsp_result", rsp_result, 16'h0000);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_acc", acc_out, 16'h0000);

        run_cmd(4'd1, 16'h0003, 16'h0004, 0, 0, r, c, e, lat, en, as);
        chk("add_result", r, 16'h0007);
        chk("add_cf", c, 1'b0);
        chk("add_latency", lat, 4);
        chk("add_en_cycles", en, 3);

        run_cmd(4'd1, 16'hFFFF, 16'h0001, 0, 0, r, c, e, lat, en, as);
        chk("carry_result", r, 16'h0000);
        chk("carry_cf", c, 1'b1);

        run_cmd(4'd5, 16'hDEAD, 16'h0010, 0, 0, r, c, e, lat, en, as);
        chk("acc1_data_a", as, 16'h0000);
        chk("acc1_acc", acc_out, 16'h0010);
        run_cmd(4'd5, 16'hDEAD, 16'h0010, 0, 0, r, c, e, lat, en, as);
        chk("acc2_data_a", as, 16'h0010);
        chk("acc2_acc", acc_out, 16'h0020);

        run_cmd(4'd0, 16'h1234, 16'h5678, 0, 0, r, c, e, lat, en, as);
        chk("nop_latency", lat, 1);
        chk("nop_en_cycles", en, 0);
        chk("nop_result", r, 16'h0000);
        chk("nop_err", e, 1'b0);

        run_cmd(4'd9, 16'h1234, 16'h5678, 0, 0, r, c, e, lat, en, as);
        chk("ill_err", e, 1'b1);
        chk("ill_result", r, 16'h0000);
        chk("ill_acc", acc_out, 16'h0020);

        run_cmd(4'd2, 16'hF0F0, 16'hFF00, 5, 1, r, c, e, lat, en, as);
        chk("bp_and_result", r, 16'hF000);
        chk("bp_after_ready", cmd_ready, 1'b1);
        cmd_opcode = 4'd1; cmd_a = 16'h0001; cmd_b = 16'h0001;
        @(negedge CLK);
        chk("bp_second_accepted", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge CLK); n++; end
        chk("bp_second_result", rsp_result, 16'h0002);
        rsp_ready = 1'b1; @(negedge CLK); rsp_ready = 1'b0;

        // Reset while the accumulate op sits in WAIT
        cmd_valid = 1'b1; cmd_opcode = 4'd5; cmd_a = 16'h0000; cmd_b = 16'h0001;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge CLK); n++; end
        @(negedge CLK);
        cmd_valid = 1'b0;
        chk("mid_issue_en", alu_enable, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mid_rst_en", alu_enable, 1'b0);
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_acc", acc_out, 16'h0000);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        repeat (10) begin
            @(negedge CLK);
            chk("mid_rst_no_rsp", rsp_valid, 1'b0);
        end

        for (int i = 0; i < 3000; i++) begin
            RST        = ($urandom_range(0, 299) == 0);
            cmd_valid  = ($urandom_range(0, 2) != 0);
            cmd_opcode = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(0, 15));
            cmd_a      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            cmd_b      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
        end
        RST = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
